counter_seq_ctrl: RTL and testbench
===================================

// Module: counter_seq_ctrl
// PURPOSE
//  Sequencer for the 10-bit up/down counter datapath. Accepts step commands on a
//  valid/ready interface and drives the counter's mode/enable/clear controls.
//  Keeps a shadow count and checks the counter's readback after every command.
//  Sits between the command source and the counter instance (cnt_reg[CNT_W-1:0]).
// PARAMETERS
//  CNT_W   10  counter width; shadow and readback width
//  STEP_W  8   width of cmd_steps; a command runs at most 2^STEP_W-1 steps
// PORTS
//  clk        in   1       clock; all state changes on rising edge
//  rst        in   1       asynchronous, active-low reset
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       controller can accept a command
//  cmd_dir    in   1       1 = count up, 0 = count down
//  cmd_steps  in   STEP_W  number of enabled counter cycles to issue
//  cmd_clear  in   1       clear counter and shadow before stepping
//  err_clr    in   1       clears sticky err
//  cnt_value  in   CNT_W   registered counter output (readback)
//  cnt_mode   out  1       counter mode; 1 = up, 0 = down
//  cnt_en     out  1       counter step enable
//  cnt_clr    out  1       synchronous counter clear
//  busy       out  1       command in progress (state != IDLE)
//  done       out  1       one-cycle pulse when a command finishes
//  err        out  1       sticky readback-mismatch flag
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, shadow=0, step counter=0, all outputs 0
//    except cmd_ready=1 after release. Reset mid-command aborts it; no done pulse.
//  - cmd_ready = (state==IDLE). A command is accepted on the edge where
//    cmd_valid && cmd_ready. dir/steps/clear are latched at that edge.
//  - FSM: IDLE -> CLEAR if clear; IDLE -> RUN if !clear && steps>0;
//    IDLE -> CHECK if !clear && steps==0.
//    CLEAR (1 cycle): cnt_clr=1, shadow<=0; -> RUN if steps>0, else CHECK.
//    RUN: cnt_en=1, cnt_mode=dir, for exactly `steps` consecutive cycles.
//      Each cycle, shadow +/- 1 and the remaining-step count decrements. -> CHECK.
//    CHECK (1 cycle): done=1; err<=1 if cnt_value!=shadow; -> IDLE.
//  - Latency: cycles from accept to done = clear + steps + 1.
//  - cnt_mode holds the last dir outside RUN. cnt_en/cnt_clr are 0 outside
//    RUN/CLEAR.
//  - Shadow arithmetic is modulo 2^CNT_W: 1023+1 -> 0, 0-1 -> 1023.
//  - err is sticky. err_clr clears it. If err_clr and a new mismatch occur in the
//    same cycle, the set wins.
// CONFIGURATION
//  - COUNTER_SEQ_SATURATE_EN defined:
//    - RUN ends early when the shadow reaches 2^CNT_W-1 (up) or 0 (down).
//    - cnt_en drops in that same cycle, so the counter does not wrap.
//    - The remaining steps are discarded and the FSM goes to CHECK.
//    - A command that starts already at the bound issues no enabled cycles.
//  - Macro undefined: the full step count is always issued and both counts wrap.
// STRUCTURE
//  - Package counter_seq_pkg holds:
//    - state typedef enum {IDLE, CLEAR, RUN, CHECK}
//    - localparams CNT_W_DEF=10 and STEP_W_DEF=8
//  - Sub-module counter_seq_shadow: shadow register with clear, inc/dec and
//    optional saturation. It outputs the shadow value and an at_bound flag.
//  - The FSM, step counter and err logic stay in the top module.
// TESTING
//  - Reset then clear=1, dir=1, steps=5: accepted at cycle 0; cnt_clr at cycle 1;
//    cnt_en in cycles 2-6; done at cycle 7; cnt_value=5, err=0.
//  - From 5, dir=0, steps=3 with no clear: cnt_mode=0 for 3 cycles, done after 4
//    cycles, shadow=2, no err.
//  - Wrap (macro off): clear, dir=0, steps=1 -> shadow=1023, matches counter.
//    Saturate (macro on): the same command issues 0 enables, shadow=0.
//  - Readback mismatch: force cnt_value=7 while shadow=5 in CHECK -> err=1 stays
//    high. err_clr in a later idle cycle -> err=0.
//  - steps=0, clear=0: done the cycle after accept, no cnt_en or cnt_clr.
//    cmd_valid held high with back-to-back commands: accepted only in IDLE.
//  - Drive rst low during RUN at step 2 of 6: outputs 0 immediately, no done.
//    After release a new command is accepted normally.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared types and default widths for the counter sequencer.
// Optional build macro: COUNTER_SEQ_SATURATE_EN (stop stepping at the count bound).
package counter_seq_pkg;

  localparam int CNT_W_DEF  = 10;
  localparam int STEP_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    CHECK = 2'd3
  } state_e;

endpackage

// File: rtl/counter_seq_shadow.sv
// Shadow copy of the counter: clear, +/-1 step and optional saturation.
// COUNTER_SEQ_SATURATE_EN defined: steps that would leave [0, 2^CNT_W-1] are suppressed.
module counter_seq_shadow
  import counter_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             step,
  input  logic             dir,
  output logic [CNT_W-1:0] value,
  output logic             at_bound
);

  localparam logic [CNT_W-1:0] MAX_V  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ZERO_V = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_V  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] value_d;
  logic             can_step_s;

  // Next shadow value; at_bound looks at the value after this cycle's update.
  always_comb begin
`ifdef COUNTER_SEQ_SATURATE_EN
    can_step_s = dir ? (value_q != MAX_V) : (value_q != ZERO_V);
`else
    can_step_s = 1'b1;
`endif
    value_d = value_q;
    if (clr) begin
      value_d = ZERO_V;
    end else if (step && can_step_s) begin
      value_d = dir ? (value_q + ONE_V) : (value_q - ONE_V);
    end else begin
      value_d = value_q;
    end
    at_bound = dir ? (value_d == MAX_V) : (value_d == ZERO_V);
  end

  // Shadow register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= ZERO_V;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command sequencer for the up/down counter: drives clear/enable/mode and checks readback.
// Optional build macro: COUNTER_SEQ_SATURATE_EN (RUN ends when the shadow hits its bound).
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_clear,
  input  logic              err_clr,
  input  logic [CNT_W-1:0]  cnt_value,
  output logic              cnt_mode,
  output logic              cnt_en,
  output logic              cnt_clr,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef COUNTER_SEQ_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif
  localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
  localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic                dir_q, dir_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic                ready_q, ready_d;
  logic                cnt_mode_q, cnt_mode_d;
  logic                cnt_en_q, cnt_en_d;
  logic                cnt_clr_q, cnt_clr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                accept_s;
  logic                mismatch_s;
  logic                sat_stop_s;
  logic                shadow_dir_s;
  logic                shadow_clr_s;
  logic                shadow_step_s;
  logic                at_bound_s;
  logic [CNT_W-1:0]    shadow_s;

  counter_seq_shadow #(.CNT_W(CNT_W)) u_shadow (
    .clk      (clk),
    .rst_n    (rst),
    .clr      (shadow_clr_s),
    .step     (shadow_step_s),
    .dir      (shadow_dir_s),
    .value    (shadow_s),
    .at_bound (at_bound_s)
  );

  // Shadow controls depend only on the current state, keeping at_bound loop-free.
  always_comb begin
    shadow_dir_s  = (state_q == IDLE) ? cmd_dir : dir_q;
    shadow_clr_s  = (state_q == CLEAR);
    shadow_step_s = (state_q == RUN);
  end

  // Next state, step counter, sticky error and the registered output values.
  always_comb begin
    accept_s   = cmd_valid && ready_q;
    sat_stop_s = SAT_EN && at_bound_s;
    mismatch_s = (state_q == CHECK) && (cnt_value != shadow_s);
    state_d    = state_q;
    dir_d      = dir_q;
    steps_d    = steps_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          dir_d   = cmd_dir;
          steps_d = cmd_steps;
          if (cmd_clear) begin
            state_d = CLEAR;
          end else if ((cmd_steps != STEP_ZERO) && !sat_stop_s) begin
            state_d = RUN;
          end else begin
            state_d = CHECK;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if ((steps_q != STEP_ZERO) && !sat_stop_s) begin
          state_d = RUN;
        end else begin
          state_d = CHECK;
        end
      end
      RUN: begin
        if ((steps_q == STEP_ONE) || sat_stop_s) begin
          state_d = CHECK;
          steps_d = STEP_ZERO;
        end else begin
          state_d = RUN;
          steps_d = steps_q - STEP_ONE;
        end
      end
      CHECK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A mismatch in CHECK outranks a simultaneous err_clr.
    if (mismatch_s) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    ready_d    = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
    cnt_en_d   = (state_d == RUN);
    cnt_clr_d  = (state_d == CLEAR);
    done_d     = (state_d == CHECK);
    cnt_mode_d = (state_d == RUN) ? dir_d : cnt_mode_q;
  end

  // FSM state, command latches and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      steps_q    <= STEP_ZERO;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      cnt_en_q   <= 1'b0;
      cnt_clr_q  <= 1'b0;
      done_q     <= 1'b0;
      cnt_mode_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      steps_q    <= steps_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      cnt_en_q   <= cnt_en_d;
      cnt_clr_q  <= cnt_clr_d;
      done_q     <= done_d;
      cnt_mode_q <= cnt_mode_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign cnt_en    = cnt_en_q;
  assign cnt_clr   = cnt_clr_q;
  assign done      = done_q;
  assign cnt_mode  = cnt_mode_q;
  assign err       = err_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural counter and a command scoreboard.
// Expectations follow COUNTER_SEQ_SATURATE_EN when the bench is built with it.
module tb_counter_seq_ctrl;

  localparam int CNT_W  = 10;
  localparam int STEP_W = 8;
  localparam int MOD    = 1 << CNT_W;

  typedef struct {
    int acc;
    int lat;
    int en;
    int clr;
    int val;
    int dir;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_dir = 1'b0;
  logic              cmd_clear = 1'b0;
  logic              err_clr = 1'b0;
  logic [STEP_W-1:0] cmd_steps = '0;
  logic              force_en = 1'b0;
  logic [CNT_W-1:0]  force_val = '0;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_value;
  logic              cmd_ready, cnt_mode, cnt_en, cnt_clr, busy, done, err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_sh = 0;
  int   en_seen = 0;
  int   clr_seen = 0;
  int   bad_mode = 0;
  exp_t sb[$];

  counter_seq_ctrl #(.CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .cmd_clear (cmd_clear),
    .err_clr   (err_clr),
    .cnt_value (cnt_value),
    .cnt_mode  (cnt_mode),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counter datapath being sequenced.
  always @(posedge clk or negedge rst) begin
    if (!rst) cnt_r <= '0;
    else if (cnt_clr) cnt_r <= '0;
    else if (cnt_en) cnt_r <= cnt_mode ? cnt_r + 1'b1 : cnt_r - 1'b1;
  end

  assign cnt_value = force_en ? force_val : cnt_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic void model(input int start, input logic clear, input logic dir,
                                input int steps, output int v, output int en);
    v  = clear ? 0 : start;
    en = 0;
    for (int i = 0; i < steps; i++) begin
`ifdef COUNTER_SEQ_SATURATE_EN
      if ((dir && v == MOD - 1) || (!dir && v == 0)) break;
`endif
      v = dir ? (v + 1) % MOD : (v + MOD - 1) % MOD;
      en++;
    end
  endfunction

  // Drive one command, push its expectation when it is accepted.
  task automatic send(input logic clear, input logic dir, input int steps,
                      input bit hold, input int force_v);
    int   v, en;
    exp_t e;
    model(exp_sh, clear, dir, steps, v, en);
    @(negedge clk);
    cmd_clear = clear;
    cmd_dir   = dir;
    cmd_steps = steps[STEP_W-1:0];
    cmd_valid = 1'b1;
    for (int i = 0; i < 100 && cmd_ready !== 1'b1; i++) @(negedge clk);
    chk("ready_wait", cmd_ready, 1'b1);
    e.acc = cyc;
    e.lat = int'(clear) + en + 1;
    e.en  = en;
    e.clr = int'(clear);
    e.val = (force_v >= 0) ? force_v : v;
    e.dir = int'(dir);
    sb.push_back(e);
    exp_sh = v;
    @(negedge clk);
    chk("ready_low_busy", cmd_ready, 1'b0);
    chk("busy_after_accept", busy, 1'b1);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", sb.size(), 0);
  endtask

  // Completion monitor: compares each done pulse against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sb.delete();
        en_seen  = 0;
        clr_seen = 0;
        bad_mode = 0;
      end else begin
        if (cnt_en === 1'b1) begin
          en_seen++;
          if (sb.size() > 0 && cnt_mode !== sb[0].dir[0]) bad_mode++;
        end
        if (cnt_clr === 1'b1) clr_seen++;
        if (done === 1'b1) begin
          if (sb.size() == 0) begin
            chk("done_unexpected", done, 1'b0);
          end else begin
            e = sb.pop_front();
            chk("latency", cyc - e.acc, e.lat);
            chk("en_cycles", en_seen, e.en);
            chk("clr_cycles", clr_seen, e.clr);
            chk("readback", cnt_value, e.val);
            chk("mode_during_run", bad_mode, 0);
          end
          en_seen  = 0;
          clr_seen = 0;
          bad_mode = 0;
        end
      end
    end
  end

  initial begin
    int done_seen;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cnt_en", cnt_en, 1'b0);
    chk("rst_cnt_clr", cnt_clr, 1'b0);
    chk("rst_cnt_mode", cnt_mode, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1'b1);

    // clear, up 5
    send(1'b1, 1'b1, 5, 1'b0, -1);
    wait_idle();
    @(negedge clk);
    chk("err_after_up5", err, 1'b0);

    // down 3 from 5, mode holds 0 afterwards
    send(1'b0, 1'b0, 3, 1'b0, -1);
    wait_idle();
    @(negedge clk);
    chk("mode_holds_down", cnt_mode, 1'b0);
    chk("err_after_down3", err, 1'b0);

    // wrap below zero, then wrap above max
    send(1'b1, 1'b0, 1, 1'b0, -1);
    wait_idle();
    send(1'b0, 1'b1, 3, 1'b0, -1);
    wait_idle();
    @(negedge clk);
    chk("err_after_wraps", err, 1'b0);

    // forced readback mismatch, sticky err, then clear in idle
    force_val = 10'd7;
    force_en  = 1'b1;
    send(1'b1, 1'b1, 5, 1'b0, 7);
    wait_idle();
    @(negedge clk);
    chk("err_set", err, 1'b1);
    force_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_cleared", err, 1'b0);

    // mismatch in the same cycle as err_clr: set wins
    force_en = 1'b1;
    err_clr  = 1'b1;
    send(1'b0, 1'b1, 0, 1'b0, 7);
    wait_idle();
    @(negedge clk);
    err_clr  = 1'b0;
    force_en = 1'b0;
    chk("err_set_wins", err, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_cleared2", err, 1'b0);

    // zero-step command, then back-to-back with cmd_valid held high
    send(1'b0, 1'b0, 0, 1'b0, -1);
    wait_idle();
    send(1'b0, 1'b1, 2, 1'b1, -1);
    send(1'b1, 1'b0, 1, 1'b1, -1);
    send(1'b0, 1'b0, 0, 1'b0, -1);
    wait_idle();

    // reset during RUN at step 2 of 6
    send(1'b0, 1'b1, 6, 1'b0, -1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_cnt_en", cnt_en, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_mode", cnt_mode, 1'b0);
    exp_sh = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    chk("no_done_after_abort", done_seen, 0);
    send(1'b0, 1'b1, 2, 1'b0, -1);
    wait_idle();
    @(negedge clk);
    chk("err_after_restart", err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the directed sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
